// File: rtl/mini_cpu_pkg.sv
// Shared mini-cpu datapath package.
// Holds the 2-bit state encoding used by the serial adder sequencer.
package mini_cpu_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_RUN  = 2'd1;
  localparam logic [1:0] ENC_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_RUN  = ENC_RUN,
    ST_DONE = ENC_DONE
  } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Ports: a, b, carry_in -> sum, carry_out (all 1 bit, purely combinational).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, registered carry, LSB first.
// Operands in over in_valid/in_ready, result out over out_valid/out_ready.
// Ports:
//   clk, rst (async, active-high)
//   in_valid, in_ready, a, b, carry_in, [sub]
//   out_valid, out_ready, sum, carry_out, overflow
// Build option: SERIAL_ADDER_SUB_EN adds the sub port (a - b when sub=1).
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | in_ready high, waiting for operands
// RUN     | one bit per cycle through the adder cell
// DONE    | result held on outputs until out_ready
module serial_adder
  import mini_cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             carry_out_q;
  logic             ovf_q;

  logic             fa_sum, fa_cout;
  logic             last;
  logic [WIDTH-1:0] b_ld;
  logic             cin_ld;

  // Subtraction is a + ~b + 1, so the operand is inverted once at load and
  // the serial loop itself never knows which operation it is running.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld   = sub ? ~b : b;
  assign cin_ld = sub ? 1'b1 : carry_in;
`else
  assign b_ld   = b;
  assign cin_ld = carry_in;
`endif

  full_adder u_fa (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  assign last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry_q     <= 1'b0;
      cnt         <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b_ld;
            carry_q <= cin_ld;
            cnt     <= '0;
            sum_sh  <= '0;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry_q <= fa_cout;
          cnt     <= cnt + CW'(1);
          if (last) begin
            carry_out_q <= fa_cout;
            // carry into the MSB differs from carry out of it => signed overflow
            ovf_q       <= carry_q ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_sh;
  assign carry_out = carry_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         sub_s = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub_s),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       input logic ms, output logic [W-1:0] es, output logic ec,
                       output logic eo);
    int unsigned tot;
    int          sa, sb, tr;
    sa = $signed(ma);
    sb = $signed(mb);
    if (ms) begin
      tot = int'(ma) + (int'(~mb) & 32'hFF) + 1;
      tr  = sa - sb;
    end else begin
      tot = int'(ma) + int'(mb) + int'(mc);
      tr  = sa + sb + int'(mc);
    end
    es = tot[W-1:0];
    ec = tot[W];
    eo = (tr > 127) || (tr < -128);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, measure latency, check the result; leaves out_valid high.
  task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic oc, input logic os);
    logic [W-1:0] es;
    logic ec, eo;
    int cnt;
    model(oa, ob, oc, os, es, ec, eo);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = oa; b = ob; carry_in = oc; sub_s = os; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, ".latency"}, 32'(cnt), 32'(W));
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".carry_out"}, 32'(carry_out), 32'(ec));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".take_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".take_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, hold_sum;
    logic rc, rs, hold_c, hold_o;

    // Reset state
    tick(); tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.carry_out", 32'(carry_out), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
    take("zero");
    run_op("ucarry", 8'hFF, 8'h01, 1'b0, 1'b0);
    take("ucarry");
    run_op("sovf", 8'h7F, 8'h00, 1'b1, 1'b0);
    chk("sovf.exact_sum", 32'(sum), 32'h80);
    take("sovf");
    run_op("plain", 8'h12, 8'h34, 1'b0, 1'b0);
    chk("plain.exact_sum", 32'(sum), 32'h46);
    // Back-to-back: next accept right after the take.
    take("plain");

    // Backpressure with a competing in_valid pulse
    run_op("bp", 8'hA5, 8'h3C, 1'b1, 1'b0);
    hold_sum = sum; hold_c = carry_out; hold_o = overflow;
    for (int i = 0; i < 5; i++) begin
      a = 8'h11; b = 8'h22; in_valid = (i % 2 == 0);
      tick();
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.sum_hold", 32'(sum), 32'(hold_sum));
      chk("bp.c_hold", 32'(carry_out), 32'(hold_c));
      chk("bp.o_hold", 32'(overflow), 32'(hold_o));
    end
    in_valid = 1'b0;
    take("bp");

    // Reset mid-operation; previous carry_out=1 so zeroing is visible
    run_op("pre", 8'hFF, 8'h01, 1'b0, 1'b0);
    take("pre");
    a = 8'h55; b = 8'h00; carry_in = 1'b0; sub_s = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid.busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.sum", 32'(sum), 32'd0);
    chk("mid.carry_out", 32'(carry_out), 32'd0);
    chk("mid.overflow", 32'(overflow), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    run_op("after", 8'h0F, 8'h01, 1'b0, 1'b0);
    chk("after.exact_sum", 32'(sum), 32'h10);
    take("after");

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub1", 8'h05, 8'h07, 1'b1, 1'b1);
    chk("sub1.exact", 32'({carry_out, overflow, sum}), 32'h0FE);
    take("sub1");
    run_op("sub2", 8'h80, 8'h01, 1'b0, 1'b1);
    chk("sub2.exact", 32'({carry_out, overflow, sum}), 32'h37F);
    take("sub2");
`endif

    // Random operations with random consumer stalls
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op("rand", ra, rb, rc, rs);
      repeat ($urandom_range(0, 3)) tick();
      chk("rand.stall_valid", 32'(out_valid), 32'd1);
      take("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder for the mini-cpu datapath. It accepts two operands over a valid/ready handshake and processes one bit per clock, LSB first, through a single `full_adder` instance with a registered carry. It returns sum, carry and signed overflow over a second valid/ready handshake. It sits directly downstream of the operand registers and feeds its result to the write-back path, trading WIDTH cycles of latency for one adder cell.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block idle and able to accept; decoded from state.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `carry_in`  in  1  initial carry.
- `sub`  in  1  subtract select; present only with `SERIAL_ADDER_SUB_EN`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  result.
- `carry_out`  out  1  carry out of the MSB.
- `overflow`  out  1  two's-complement overflow.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `a` and `b` into shift registers and load the carry register with `carry_in`.
  - Clear the bit counter, clear the sum shift register, then go to RUN.
- **RUN**
  - Each cycle the full adder takes a_sh[0], b_sh[0] and the carry register.
  - The sum bit shifts into sum_sh at the MSB; sum_sh shifts right.
  - a_sh and b_sh shift right; the carry register takes the adder's carry out.
  - The counter increments each cycle.
  - On the cycle with count==WIDTH-1:
    - register `carry_out` from the adder;
    - register `overflow` = (carry register) XOR (adder carry out), i.e. carry into the MSB XOR carry out of it;
    - go to DONE.
- **DONE**
  - `out_valid`=1; `sum`, `carry_out` and `overflow` are held stable.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored outside IDLE.
- The counter is $clog2(WIDTH) bits wide, and the terminal-count compare is against WIDTH-1.
- **Reset mid-operation:** at any point, reset goes to IDLE, discards any partial result, and zeroes all outputs.

## Timing
- **Reset values:**
  - `out_valid`=0, `sum`=0, `carry_out`=0, `overflow`=0.
  - State = IDLE, so `in_ready`=1 once `rst` deasserts.
- **Latency:** for an accept at edge E (`in_valid`&`in_ready`), `out_valid` rises after edge E+WIDTH.
- **Throughput:** with `out_ready` held high, the result is taken at edge E+WIDTH+1, `in_ready`=1 in the following cycle, and the next accept can occur at edge E+WIDTH+2.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, all outputs hold and `in_ready`=0, for an unbounded time.
- **Final cycle:**
  - `out_valid` and `out_ready` are both registered/sampled on the same edge as the transfer.
  - No combinational path from `in_valid` to `out_valid`.
  - `out_ready` does not combinationally affect `in_ready` in the same cycle.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - The `sub` port exists and is latched at accept.
  - With `sub`=1: b is inverted bitwise at load, and the carry register is loaded with 1 (`carry_in` ignored).
  - `carry_out`=1 means no borrow; `overflow` is signed subtraction overflow.
  - With `sub`=0: behaviour is identical to the add-only build.
- `SERIAL_ADDER_SUB_EN` undefined:
  - No `sub` port and no inverter; add only, with `carry_in` honoured.

## Structure
- **Shared package `mini_cpu_pkg`:** the state encoding for IDLE/RUN/DONE as localparams (2 bits).
- **Sub-module:** one instance of the existing `full_adder` (ports a, b, carry_in, sum, carry_out). No other sub-modules.
- **Registers:** a_sh, b_sh, sum_sh, carry register, counter, state, latched sub.

## Test plan
Run with WIDTH=8.
- **Reset then zero add:** reset, then accept 8'h00 + 8'h00, `carry_in`=0.
  - `out_valid` exactly 8 edges after accept.
  - `sum`=00, `carry_out`=0, `overflow`=0.
- **Unsigned carry:** 8'hFF + 8'h01, `carry_in`=0.
  - `sum`=00, `carry_out`=1, `overflow`=0.
- **Signed overflow with carry_in:**
  - 8'h7F + 8'h00, `carry_in`=1 gives `sum`=80, `carry_out`=0, `overflow`=1.
  - 8'h12 + 8'h34 gives 8'h46, `overflow`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` and pulse `in_valid` with new operands.
  - Outputs are stable and `in_ready`=0; the new operands are not accepted.
  - After `out_ready`, `in_ready`=1 in the next cycle.
- **Reset mid-operation:** assert `rst` 3 cycles into RUN.
  - Outputs go to 0 immediately, state is IDLE, `in_ready`=1 after release.
  - The next op 8'h0F + 8'h01 gives `sum`=10.
- **SERIAL_ADDER_SUB_EN:**
  - 8'h05 − 8'h07 gives `sum`=FE, `carry_out`=0, `overflow`=0.
  - 8'h80 − 8'h01 gives `sum`=7F, `carry_out`=1, `overflow`=1.
